sbus_shift_unit: RTL and testbench

- Multi-cycle barrel-free shifter that sits directly upstream of the switchable register bank.
- Accepts a 16-bit operand, shift operation and amount; shifts one bit per clock.
- On completion, drives the result on the S bus for exactly one cycle, together with a one-hot SR store strobe that selects the destination register.
- With SR low, every switchable register holds, so the bank needs no other write control.

---
 rtl/sbus_shift_unit_if.sv | 21 ++
 rtl/sbus_shift_unit.sv | 76 +++++++
 tb/tb_sbus_shift_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sbus_shift_unit_if.sv
// sbus_shift_unit_if: request/result bundle between a shift requester and sbus_shift_unit
//   START/OP/A/AMT/DEST : request from master (operation, operand, amount, target register)
//   BUSY/DONE/CF        : status back to master
//   S_bus/SR            : result bus and one-hot store strobe toward the register bank
interface sbus_shift_unit_if #(
    parameter int NREG   = 8,
    parameter int DEST_W = 3
);
    logic              START;
    logic [1:0]        OP;
    logic [15:0]       A;
    logic [3:0]        AMT;
    logic [DEST_W-1:0] DEST;
    logic              BUSY;
    logic              DONE;
    logic              CF;
    logic [15:0]       S_bus;
    logic [NREG-1:0]   SR;
    modport master (output START, OP, A, AMT, DEST, input BUSY, DONE, CF, S_bus, SR);
    modport slave  (input START, OP, A, AMT, DEST, output BUSY, DONE, CF, S_bus, SR);
endinterface

// File: rtl/sbus_shift_unit.sv
// sbus_shift_unit: bit-serial 16-bit shifter that writes its result into a switchable register bank
//   CLK, CLR : clock, synchronous active-high reset
//   bus      : slave side of sbus_shift_unit_if (request in, BUSY/DONE/CF status, S_bus + SR strobe out)
module sbus_shift_unit #(
    parameter int NREG   = 8,
    parameter int DEST_W = 3
) (
    input logic              CLK,
    input logic              CLR,
    sbus_shift_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;
    state_t            state_q, state_d;
    logic [15:0]       w_q, w_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic              cf_q, cf_d;
    logic              write;
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= IDLE;
            w_q     <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            dest_q  <= '0;
            cf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            dest_q  <= dest_d;
            cf_q    <= cf_d;
        end
    end
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        dest_d  = dest_q;
        cf_d    = cf_q;
        case (state_q)
            IDLE: if (bus.START) begin
                w_d     = bus.A;
                cnt_d   = bus.AMT;
                op_d    = bus.OP;
                dest_d  = bus.DEST;
                cf_d    = 1'b0;
                state_d = (bus.AMT == 4'd0) ? WRITE : SHIFT;
            end
            SHIFT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? WRITE : SHIFT;
                case (op_q)
                    2'b00:   {cf_d, w_d} = {w_q, 1'b0};
                    2'b01:   {w_d, cf_d} = {1'b0, w_q};
                    2'b10:   {w_d, cf_d} = {w_q[15], w_q};
                    default: {cf_d, w_d} = {w_q, w_q[15]};
                endcase
            end
            default: state_d = IDLE;
        endcase
    end
    assign write     = (state_q == WRITE);
    assign bus.BUSY  = (state_q != IDLE);
    assign bus.DONE  = write;
    assign bus.CF    = cf_q;
    // Zero outside WRITE so several sources can OR onto the same S bus.
    assign bus.S_bus = write ? w_q : 16'h0000;
    // An out-of-range destination matches no strobe, so the op completes without a write.
    for (genvar i = 0; i < NREG; i++) begin : g_sr
        assign bus.SR[i] = write && (dest_q == DEST_W'(i));
    end
endmodule

// File: tb/tb_sbus_shift_unit.sv
module tb_sbus_shift_unit;
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    sbus_shift_unit_if #(.NREG(8), .DEST_W(3)) if8 ();
    sbus_shift_unit_if #(.NREG(6), .DEST_W(3)) if6 ();
    assign if6.START = if8.START;
    assign if6.OP    = if8.OP;
    assign if6.A     = if8.A;
    assign if6.AMT   = if8.AMT;
    assign if6.DEST  = if8.DEST;

    sbus_shift_unit #(.NREG(8), .DEST_W(3)) u8 (.CLK(clk), .CLR(clr), .bus(if8.slave));
    sbus_shift_unit #(.NREG(6), .DEST_W(3)) u6 (.CLK(clk), .CLR(clr), .bus(if6.slave));

    logic [15:0] bank [8];
    always @(posedge clk)
        for (int i = 0; i < 8; i++)
            if (if8.SR[i]) bank[i] <= if8.S_bus;

    typedef struct {
        logic [15:0] s;
        logic        cf;
        logic [2:0]  dest;
        int          amt;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [1:0] op, input logic [15:0] a, input int amt);
        logic [15:0] w = a;
        logic        c = 1'b0;
        for (int i = 0; i < amt; i++) begin
            case (op)
                2'b00: begin c = w[15]; w = w << 1; end
                2'b01: begin c = w[0];  w = w >> 1; end
                2'b10: begin c = w[0];  w = {w[15], w[15:1]}; end
                default: begin c = w[15]; w = {w[14:0], w[15]}; end
            endcase
        end
        return {c, w};
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [3:0] amt,
                         input logic [2:0] dest, input bit poke,
                         input logic [15:0] exp_s, input logic exp_cf);
        exp_t e;
        int   k;
        int   extra;
        e.s = exp_s; e.cf = exp_cf; e.dest = dest; e.amt = int'(amt);
        sb.push_back(e);
        @(negedge clk);
        if8.START = 1'b1; if8.OP = op; if8.A = a; if8.AMT = amt; if8.DEST = dest;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                if8.START = 1'b0;
                if8.A     = 16'($urandom);
                if8.AMT   = 4'($urandom);
                if8.OP    = 2'($urandom);
                if8.DEST  = 3'($urandom);
            end
            if (poke) if8.START = (k == 2);
        end while (!if8.DONE && k < 40);
        if8.START = 1'b0;
        e = sb.pop_front();
        chk("latency", k, e.amt + 1);
        chk("s_bus", if8.S_bus, e.s);
        chk("cf", if8.CF, e.cf);
        chk("sr8", if8.SR, 8'h01 << e.dest);
        chk("busy_write", if8.BUSY, 1);
        chk("sr6", if6.SR, (e.dest < 6) ? (6'h01 << e.dest) : 6'h00);
        chk("done6", if6.DONE, 1);
        @(negedge clk);
        chk("idle_busy", if8.BUSY, 0);
        chk("idle_sr", if8.SR, 0);
        chk("idle_sbus", if8.S_bus, 0);
        chk("cf_hold", if8.CF, e.cf);
        chk("bank", bank[e.dest], e.s);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (if8.DONE) extra++;
        end
        chk("extra_done", extra, 0);
    endtask

    initial begin
        logic [16:0] m;
        logic [1:0]  rop;
        logic [15:0] ra;
        logic [3:0]  ramt;
        logic [2:0]  rdest;
        int          k;
        int          n;
        int          t [2];

        clr = 1'b1;
        if8.START = 1'b1; if8.OP = 2'b00; if8.A = 16'hFFFF; if8.AMT = 4'd3; if8.DEST = 3'd1;
        repeat (2) @(negedge clk);
        chk("rst_busy", if8.BUSY, 0);
        chk("rst_done", if8.DONE, 0);
        chk("rst_sr", if8.SR, 0);
        chk("rst_sbus", if8.S_bus, 0);
        chk("rst_cf", if8.CF, 0);
        clr = 1'b0;
        if8.START = 1'b0;
        @(negedge clk);
        chk("rst_idle", if8.BUSY, 0);

        do_op(2'b00, 16'h8001, 4'd1,  3'd2, 1'b0, 16'h0002, 1'b1);
        do_op(2'b10, 16'hF000, 4'd4,  3'd0, 1'b0, 16'hFF00, 1'b0);
        do_op(2'b11, 16'h8000, 4'd15, 3'd7, 1'b0, 16'h4000, 1'b0);
        do_op(2'b01, 16'h1234, 4'd0,  3'd5, 1'b0, 16'h1234, 1'b0);
        do_op(2'b01, 16'hA5A5, 4'd6,  3'd3, 1'b1, 16'h0296, 1'b1);

        @(negedge clk);
        if8.START = 1'b1; if8.OP = 2'b01; if8.A = 16'hFFFF; if8.AMT = 4'd8; if8.DEST = 3'd3;
        @(negedge clk);
        if8.START = 1'b0;
        @(negedge clk);
        chk("mid_cf_set", if8.CF, 1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("abort_busy", if8.BUSY, 0);
        chk("abort_cf", if8.CF, 0);
        chk("abort_sr", if8.SR, 0);
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (if8.DONE || if8.SR != 0) n++;
        end
        chk("abort_no_write", n, 0);
        do_op(2'b01, 16'hFFFF, 4'd8, 3'd4, 1'b0, 16'h00FF, 1'b1);

        for (int r = 0; r < 4; r++) begin
            rop   = 2'($urandom);
            ra    = 16'($urandom);
            ramt  = 4'($urandom);
            rdest = 3'($urandom);
            m     = model(rop, ra, int'(ramt));
            do_op(rop, ra, ramt, rdest, 1'b0, m[15:0], m[16]);
        end

        @(negedge clk);
        if8.START = 1'b1; if8.OP = 2'b00; if8.A = 16'h0F0F; if8.AMT = 4'd3; if8.DEST = 3'd1;
        n = 0;
        k = 0;
        while (n < 2 && k < 30) begin
            @(negedge clk);
            k++;
            if (if8.DONE) begin
                chk("b2b_sbus", if8.S_bus, 16'h7878);
                chk("b2b_sr", if8.SR, 8'h02);
                t[n] = k;
                n++;
            end
        end
        if8.START = 1'b0;
        chk("b2b_count", n, 2);
        if (n == 2) chk("b2b_spacing", t[1] - t[0], 5);
        repeat (3) @(negedge clk);
        chk("final_idle", if8.BUSY, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
